inst_mem_ctrl: RTL

INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

---
 rtl/inst_mem_ctrl_if.sv | 27 ++
 rtl/inst_mem_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl_if.sv
// Fetch and program-load bus between the core and the instruction memory controller.
// Handshake: a fetch is taken when req_i=1 and busy_o=0 at a rising edge; rvalid_o pulses once per taken fetch.
interface inst_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic [ADDR_W-1:0] addr_i;
  logic              busy_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;
  logic              err_o;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic [31:0]       fetch_cnt_o;

  modport master (
    output req_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
    input  busy_o, rdata_o, rvalid_o, err_o, fetch_cnt_o
  );

  modport slave (
    input  req_i, addr_i, ld_we_i, ld_addr_i, ld_data_i,
    output busy_o, rdata_o, rvalid_o, err_o, fetch_cnt_o
  );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: fixed-latency fetch with wait states, fault detection,
// a program-load write port and a saturating completed-fetch counter.
module inst_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4096,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  inst_mem_ctrl_if.slave bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]        WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [DATA_W-1:0] NOP_WORD  = DATA_W'(32'h0000_0013);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic [31:0]       r_fetch_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_cap_addr;
  logic [ADDR_W-1:0] w_cap_idx;
  logic              w_cap_err;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_ld_ok;

  assign w_accept = bus.req_i && ((r_state == S_IDLE) || (r_state == S_RESP));

  always_comb begin
    w_next_state   = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (WAIT_CYC == 0) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state   = S_WAIT;
            w_wait_cnt_nxt = WAIT_LOAD;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = S_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 4'd1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // With zero wait states the capture edge is the acceptance edge, so the live address is used.
  assign w_enter_resp = (w_next_state == S_RESP);
  assign w_cap_addr   = (r_state == S_WAIT) ? r_addr : bus.addr_i;
  assign w_cap_idx    = {2'b00, w_cap_addr[ADDR_W-1:2]};
  assign w_cap_err    = (w_cap_addr[1:0] != 2'b00) || (w_cap_idx >= DEPTH_A);
  assign w_cap_data   = w_cap_err ? NOP_WORD : r_mem[w_cap_idx[IDX_W-1:0]];
  assign w_ld_ok      = (bus.ld_addr_i < DEPTH_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_addr      <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_err       <= 1'b0;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_rvalid   <= w_enter_resp;
      r_err      <= w_enter_resp && w_cap_err;
      if (w_accept) begin
        r_addr <= bus.addr_i;
      end
      if (w_enter_resp) begin
        r_rdata <= w_cap_data;
        if (r_fetch_cnt != 32'hFFFF_FFFF) begin
          r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
      end
    end
  end

  // Memory has no reset; a same-edge load and capture of one word returns the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst && bus.ld_we_i && w_ld_ok) begin
      r_mem[bus.ld_addr_i[IDX_W-1:0]] <= bus.ld_data_i;
    end
  end

  assign bus.busy_o      = (r_state == S_WAIT);
  assign bus.rdata_o     = r_rdata;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.err_o       = r_err;
  assign bus.fetch_cnt_o = r_fetch_cnt;
  assign o_dbg_state     = r_state;

endmodule
